// File: rtl/ets_pkg.sv
// Shared definitions for the equivalent-time-sampling phase-shift sweep.
//   ps_state_t            : sweep sequencer states
//   FINE_PS_STEPS_PER_VCO : MMCM fine phase-shift steps per VCO period
//   period_steps()        : fine-PS steps per output-clock period for a given
//                           output divider
package ets_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DONE = 3'd2,
      DWELL     = 3'd3,
      FINISH    = 3'd4
   } ps_state_t;

   localparam int unsigned FINE_PS_STEPS_PER_VCO = 56;

   function automatic int unsigned period_steps(input int unsigned fixed_div);
      return FINE_PS_STEPS_PER_VCO * fixed_div;
   endfunction

endpackage

// File: rtl/phase_pos_wrap_cnt.sv
// Modulo-PERIOD up/down counter holding the absolute MMCM phase position.
//   i_clk_sys : clock
//   i_rst_b   : asynchronous active-low reset, position -> 0
//   i_clr     : synchronous clear to 0 (priority over i_step)
//   i_step    : move one step this cycle
//   i_up      : 1 = +1, 0 = -1
//   o_pos     : position in 0..PERIOD-1
module phase_pos_wrap_cnt #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned PERIOD = 616
) (
   input  logic             i_clk_sys,
   input  logic             i_rst_b,
   input  logic             i_clr,
   input  logic             i_step,
   input  logic             i_up,
   output logic [WIDTH-1:0] o_pos
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

   logic [WIDTH-1:0] r_pos;

   always_ff @(posedge i_clk_sys or negedge i_rst_b) begin
      if (!i_rst_b) begin
         r_pos <= '0;
      end else if (i_clr) begin
         r_pos <= '0;
      end else if (i_step) begin
         if (i_up) begin
            r_pos <= (r_pos == LAST) ? '0 : r_pos + WIDTH'(1);
         end else begin
            r_pos <= (r_pos == '0) ? LAST : r_pos - WIDTH'(1);
         end
      end
   end

   assign o_pos = r_pos;

endmodule

// File: rtl/mmcm_ps_sweep_ctrl.sv
// MMCM dynamic fine phase-shift sweep sequencer. Issues one PSEN per step,
// waits for PSDONE (with timeout), dwells, then strobes the sampler.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN : clock (also MMCM PSCLK), async active-low reset
//   start, dir, num_steps, dwell : sweep command, sampled on accepted start
//   abort                     : level, ends sweep once no PSDONE is outstanding
//   pos_clear                 : zero phase_pos (IDLE only)
//   ps_en, ps_incdec, ps_done : MMCM phase-shift port
//   busy, done, timeout_err, sample_strobe, step_idx, phase_pos : status
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// ISSUE     | one-cycle PSEN, timeout counter reset
// WAIT_DONE | waiting for PSDONE or timeout
// DWELL     | settle countdown; sample_strobe on expiry
// FINISH    | one-cycle done pulse
module mmcm_ps_sweep_ctrl
   import ets_pkg::*;
#(
   parameter int unsigned POS_WIDTH      = 16,
   parameter int unsigned DWELL_WIDTH    = 16,
   parameter int unsigned PERIOD_STEPS   = period_steps(11),
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                   S_AXI_ACLK,
   input  logic                   S_AXI_ARESETN,
   input  logic                   start,
   input  logic                   dir,
   input  logic [POS_WIDTH-1:0]   num_steps,
   input  logic [DWELL_WIDTH-1:0] dwell,
   input  logic                   abort,
   input  logic                   pos_clear,
   output logic                   ps_en,
   output logic                   ps_incdec,
   input  logic                   ps_done,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_err,
   output logic                   sample_strobe,
   output logic [POS_WIDTH-1:0]   step_idx,
   output logic [POS_WIDTH-1:0]   phase_pos
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   ps_state_t              r_state;
   ps_state_t              w_next;
   logic                   r_dir;
   logic [POS_WIDTH-1:0]   r_num_steps;
   logic [POS_WIDTH-1:0]   r_step_idx;
   logic [DWELL_WIDTH-1:0] r_dwell;
   logic [DWELL_WIDTH-1:0] r_dwell_cnt;
   logic [TO_W-1:0]        r_to_cnt;
   logic                   r_abort_seen;
   logic                   r_zero_done;
   logic                   r_timeout_err;

   logic                   w_accept;
   logic                   w_zero_start;
   logic                   w_step;
   logic                   w_to_hit;
   logic                   w_dwell_exp;
   logic                   w_pos_clr;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_accept     = 1'b0;
      w_zero_start = 1'b0;
      w_step       = 1'b0;
      w_to_hit     = 1'b0;
      w_dwell_exp  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (num_steps != '0) begin
                  w_accept = 1'b1;
                  w_next   = ISSUE;
               end else begin
                  w_zero_start = 1'b1;
               end
            end
         end
         ISSUE: w_next = WAIT_DONE;
         WAIT_DONE: begin
            if (ps_done) begin
               w_step = 1'b1;
               // An abort seen while the request was outstanding skips the dwell.
               w_next = (abort || r_abort_seen) ? FINISH : DWELL;
            end else if (r_to_cnt == TO_LAST) begin
               w_to_hit = 1'b1;
               w_next   = FINISH;
            end
         end
         DWELL: begin
            if (r_dwell_cnt == '0) begin
               w_dwell_exp = 1'b1;
               w_next = ((r_step_idx == r_num_steps) || abort) ? FINISH : ISSUE;
            end
         end
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_dir         <= 1'b0;
         r_num_steps   <= '0;
         r_step_idx    <= '0;
         r_dwell       <= '0;
         r_dwell_cnt   <= '0;
         r_to_cnt      <= '0;
         r_abort_seen  <= 1'b0;
         r_zero_done   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_zero_done <= w_zero_start;

         if (w_accept) begin
            r_dir       <= dir;
            r_num_steps <= num_steps;
            r_dwell     <= dwell;
            r_step_idx  <= '0;
         end else if (w_step) begin
            r_step_idx <= r_step_idx + POS_WIDTH'(1);
         end

         if (w_accept || w_zero_start) begin
            r_timeout_err <= 1'b0;
         end else if (w_to_hit) begin
            r_timeout_err <= 1'b1;
         end

         if (r_state == ISSUE) begin
            r_to_cnt <= '0;
         end else if (r_state == WAIT_DONE && !ps_done) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end

         if (w_step) begin
            r_dwell_cnt <= r_dwell;
         end else if (r_state == DWELL && r_dwell_cnt != '0) begin
            r_dwell_cnt <= r_dwell_cnt - DWELL_WIDTH'(1);
         end

         if (w_accept) begin
            r_abort_seen <= 1'b0;
         end else if ((r_state == ISSUE || r_state == WAIT_DONE) && abort) begin
            r_abort_seen <= 1'b1;
         end
      end
   end

   assign w_pos_clr = pos_clear && (r_state == IDLE);

   phase_pos_wrap_cnt #(
      .WIDTH  (POS_WIDTH),
      .PERIOD (PERIOD_STEPS)
   ) u_pos (
      .i_clk_sys (S_AXI_ACLK),
      .i_rst_b   (S_AXI_ARESETN),
      .i_clr     (w_pos_clr),
      .i_step    (w_step),
      .i_up      (r_dir),
      .o_pos     (phase_pos)
   );

   assign ps_en         = (r_state == ISSUE);
   assign busy          = (r_state != IDLE);
   assign ps_incdec     = busy ? r_dir : 1'b0;
   assign done          = (r_state == FINISH) || r_zero_done;
   assign sample_strobe = w_dwell_exp;
   assign timeout_err   = r_timeout_err;
   assign step_idx      = r_step_idx;

endmodule

// File: tb/tb_mmcm_ps_sweep_ctrl.sv
module tb_mmcm_ps_sweep_ctrl;

   localparam int PS_LAT = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        dir = 1'b0;
   logic [15:0] num_steps = '0;
   logic [15:0] dwell = '0;
   logic        abort = 1'b0;
   logic        pos_clear = 1'b0;
   logic        ps_done = 1'b0;
   logic        mmcm_resp = 1'b1;

   logic        ps_en, ps_incdec, busy, done, timeout_err, sample_strobe;
   logic [15:0] step_idx, phase_pos;

   int n_checks = 0;
   int n_fail = 0;

   mmcm_ps_sweep_ctrl #(
      .POS_WIDTH      (16),
      .DWELL_WIDTH    (16),
      .PERIOD_STEPS   (616),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .start         (start),
      .dir           (dir),
      .num_steps     (num_steps),
      .dwell         (dwell),
      .abort         (abort),
      .pos_clear     (pos_clear),
      .ps_en         (ps_en),
      .ps_incdec     (ps_incdec),
      .ps_done       (ps_done),
      .busy          (busy),
      .done          (done),
      .timeout_err   (timeout_err),
      .sample_strobe (sample_strobe),
      .step_idx      (step_idx),
      .phase_pos     (phase_pos)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // MMCM model: PSDONE for one cycle, PS_LAT cycles after PSEN is seen.
   int n_psdone = 0;
   int last_done_cyc = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (ps_en && mmcm_resp) begin
            repeat (PS_LAT) @(negedge clk);
            ps_done = 1'b1;
            last_done_cyc = cyc;
            n_psdone++;
            @(negedge clk);
            ps_done = 1'b0;
         end
      end
   end

   // Event monitor
   int n_psen = 0, n_psen_inc = 0, n_strobe = 0, n_done = 0;
   int psen_cyc[64];
   int strobe_delta[64];
   int strobe_phase[64];
   always @(negedge clk) begin
      if (ps_en) begin
         if (n_psen < 64) psen_cyc[n_psen] = cyc;
         n_psen++;
         if (ps_incdec) n_psen_inc++;
      end
      if (sample_strobe) begin
         if (n_strobe < 64) begin
            strobe_delta[n_strobe] = cyc - last_done_cyc;
            strobe_phase[n_strobe] = int'(phase_pos);
         end
         n_strobe++;
      end
      if (done) n_done++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic d, input logic [15:0] n, input logic [15:0] dw);
      @(negedge clk);
      dir = d; num_steps = n; dwell = dw; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      pos_clear = 1'b1;
      @(negedge clk);
      pos_clear = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      logic got;
      got = done;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         got = done;
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
   endtask

   int b_psen, b_inc, b_strobe, b_done, b_psdone, seen;

   initial begin
      // ---------------- reset state
      repeat (2) @(negedge clk);
      chk("rst_flags", {26'd0, ps_en, ps_incdec, busy, done, timeout_err, sample_strobe}, 32'd0);
      chk("rst_step_idx", 32'(step_idx), 32'd0);
      chk("rst_phase", 32'(phase_pos), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ---------------- basic sweep: inc, 3 steps, dwell 4
      b_psen = n_psen; b_inc = n_psen_inc; b_strobe = n_strobe; b_done = n_done;
      do_start(1'b1, 16'd3, 16'd4);
      chk("t1_busy", 32'(busy), 32'd1);
      wait_done(200, "t1");
      chk("t1_step_idx", 32'(step_idx), 32'd3);
      chk("t1_phase", 32'(phase_pos), 32'd3);
      chk("t1_timeout_err", 32'(timeout_err), 32'd0);
      repeat (3) @(negedge clk);
      chk("t1_idle", 32'(busy), 32'd0);
      chk("t1_psen_cnt", 32'(n_psen - b_psen), 32'd3);
      chk("t1_psen_inc", 32'(n_psen_inc - b_inc), 32'd3);
      chk("t1_strobe_cnt", 32'(n_strobe - b_strobe), 32'd3);
      chk("t1_done_cnt", 32'(n_done - b_done), 32'd1);
      for (int i = 0; i < 3; i++)
         chk($sformatf("t1_strobe_lat%0d", i), 32'(strobe_delta[b_strobe + i]), 32'd5);
      // period = 1 + 12 + 4 + 1
      chk("t1_step_period", 32'(psen_cyc[b_psen + 1] - psen_cyc[b_psen]), 32'd18);

      // ---------------- wrap: clear, dec to 615, then inc through 0 to 1
      pulse_clear();
      @(negedge clk);
      chk("t2_cleared", 32'(phase_pos), 32'd0);
      b_strobe = n_strobe;
      do_start(1'b0, 16'd1, 16'd0);
      wait_done(200, "t2a");
      chk("t2a_phase", 32'(phase_pos), 32'd615);
      chk("t2a_incdec_busy", 32'(ps_incdec), 32'd0);
      do_start(1'b1, 16'd2, 16'd2);
      repeat (3) @(negedge clk);
      pos_clear = 1'b1;
      @(negedge clk);
      pos_clear = 1'b0;
      wait_done(200, "t2b");
      chk("t2b_phase", 32'(phase_pos), 32'd1);
      repeat (2) @(negedge clk);
      chk("t2_strobe_cnt", 32'(n_strobe - b_strobe), 32'd3);
      chk("t2a_strobe_phase", 32'(strobe_phase[b_strobe]), 32'd615);
      chk("t2a_strobe_lat", 32'(strobe_delta[b_strobe]), 32'd1);
      chk("t2b_strobe_phase0", 32'(strobe_phase[b_strobe + 1]), 32'd0);
      chk("t2b_strobe_phase1", 32'(strobe_phase[b_strobe + 2]), 32'd1);

      // ---------------- timeout: MMCM never answers
      mmcm_resp = 1'b0;
      b_psen = n_psen; b_strobe = n_strobe;
      do_start(1'b1, 16'd4, 16'd1);
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         if (ps_en) seen = 1;
         else @(negedge clk);
      end
      chk("t3_psen_seen", 32'(seen), 32'd1);
      repeat (63) @(negedge clk);
      chk("t3_err_not_yet", 32'(timeout_err), 32'd0);
      chk("t3_busy_waiting", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      chk("t3_err_set", 32'(timeout_err), 32'd1);
      chk("t3_done", 32'(done), 32'd1);
      @(negedge clk);
      chk("t3_idle", 32'(busy), 32'd0);
      chk("t3_err_sticky", 32'(timeout_err), 32'd1);
      chk("t3_phase_kept", 32'(phase_pos), 32'd1);
      chk("t3_step_idx", 32'(step_idx), 32'd0);
      chk("t3_psen_cnt", 32'(n_psen - b_psen), 32'd1);
      chk("t3_no_strobe", 32'(n_strobe - b_strobe), 32'd0);
      mmcm_resp = 1'b1;

      // ---------------- zero-step start: clears error, done next cycle
      b_psen = n_psen; b_done = n_done;
      do_start(1'b1, 16'd0, 16'd3);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_err_cleared", 32'(timeout_err), 32'd0);
      chk("t4_not_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("t4_done_once", 32'(n_done - b_done), 32'd1);
      chk("t4_no_psen", 32'(n_psen - b_psen), 32'd0);
      chk("t4_still_idle", 32'(busy), 32'd0);

      // ---------------- abort in WAIT_DONE of step 2 of 5
      b_psen = n_psen; b_strobe = n_strobe; b_done = n_done; b_psdone = n_psdone;
      do_start(1'b1, 16'd5, 16'd3);
      seen = 0;
      for (int i = 0; i < 200 && seen < 2; i++) begin
         if (ps_en) seen++;
         if (seen < 2) @(negedge clk);
      end
      chk("t5_second_psen", 32'(seen), 32'd2);
      @(negedge clk);
      abort = 1'b1;
      wait_done(100, "t5");
      abort = 1'b0;
      chk("t5_step_idx", 32'(step_idx), 32'd2);
      chk("t5_phase", 32'(phase_pos), 32'd3);
      repeat (20) @(negedge clk);
      chk("t5_psen_cnt", 32'(n_psen - b_psen), 32'd2);
      chk("t5_psdone_cnt", 32'(n_psdone - b_psdone), 32'd2);
      chk("t5_strobe_cnt", 32'(n_strobe - b_strobe), 32'd1);
      chk("t5_done_cnt", 32'(n_done - b_done), 32'd1);
      chk("t5_timeout_err", 32'(timeout_err), 32'd0);

      // ---------------- start while busy is ignored
      b_psen = n_psen;
      do_start(1'b1, 16'd2, 16'd2);
      repeat (4) @(negedge clk);
      do_start(1'b0, 16'd7, 16'd0);
      wait_done(200, "t6");
      chk("t6_step_idx", 32'(step_idx), 32'd2);
      chk("t6_phase", 32'(phase_pos), 32'd5);
      repeat (20) @(negedge clk);
      chk("t6_psen_cnt", 32'(n_psen - b_psen), 32'd2);
      chk("t6_idle", 32'(busy), 32'd0);

      // ---------------- reset asserted during DWELL
      b_psdone = n_psdone;
      do_start(1'b1, 16'd3, 16'd20);
      seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
         @(negedge clk);
         if (n_psdone != b_psdone) seen = 1;
      end
      chk("t7_psdone_seen", 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      chk("t7_in_dwell_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t7_rst_flags", {26'd0, ps_en, ps_incdec, busy, done, timeout_err, sample_strobe}, 32'd0);
      chk("t7_rst_phase", 32'(phase_pos), 32'd0);
      chk("t7_rst_step_idx", 32'(step_idx), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("t7_idle_after", 32'(busy), 32'd0);
      b_strobe = n_strobe;
      do_start(1'b0, 16'd1, 16'd0);
      wait_done(200, "t7");
      chk("t7_new_phase", 32'(phase_pos), 32'd615);
      chk("t7_new_step_idx", 32'(step_idx), 32'd1);
      repeat (2) @(negedge clk);
      chk("t7_new_strobe", 32'(n_strobe - b_strobe), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed time limit reached, required test completion");
      $fatal(1, "global time limit");
   end

endmodule
